// File: rtl/cpu_mem_arbiter_pkg.sv
// Shared state encoding and width defaults for the CPU memory-port arbiter.
package cpu_mem_arbiter_pkg;

    localparam int AW_DEF = 32;
    localparam int DW_DEF = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        I_ADDR = 3'd1,
        I_DATA = 3'd2,
        D_ADDR = 3'd3,
        D_DATA = 3'd4
    } arb_state_t;

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// sram-like memory port between the arbiter (master) and the cache/AXI bridge (slave).
interface cpu_mem_arbiter_if
    import cpu_mem_arbiter_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
);
    logic          mem_req;
    logic [3:0]    mem_wen;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok;
    logic          mem_data_ok;
    logic [DW-1:0] mem_rdata;

    modport master (
        output mem_req, mem_wen, mem_addr, mem_wdata,
        input  mem_addr_ok, mem_data_ok, mem_rdata
    );

    modport slave (
        input  mem_req, mem_wen, mem_addr, mem_wdata,
        output mem_addr_ok, mem_data_ok, mem_rdata
    );
endinterface

// File: rtl/cpu_mem_arbiter_resp_buf.sv
// Response holding register with a done flag; a set on the same edge as a clear wins.
module cpu_mem_arbiter_resp_buf #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          set,
    input  logic          clr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          done
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dout <= '0;
            done <= 1'b0;
        end else begin
            if (set) begin
                dout <= din;
            end
            if (set) begin
                done <= 1'b1;
            end else if (clr) begin
                done <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Shares one sram-like port between instruction fetch and data access, one transaction at a time.
// state  | meaning
// IDLE   | no transaction outstanding, arbitrating pending requests
// I_ADDR | fetch request on the port, waiting for addr_ok
// I_DATA | fetch accepted, waiting for data_ok
// D_ADDR | load/store request on the port, waiting for addr_ok
// D_DATA | load/store accepted, waiting for data_ok
module cpu_mem_arbiter
    import cpu_mem_arbiter_pkg::*;
#(
    parameter bit DATA_FIRST = 1'b1,
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inst_req,
    input  logic [AW-1:0]     inst_addr,
    output logic [DW-1:0]     inst_rdata,
    output logic              i_stall,
    input  logic              data_req,
    input  logic [3:0]        data_wen,
    input  logic [AW-1:0]     data_addr,
    input  logic [DW-1:0]     data_wdata,
    output logic [DW-1:0]     data_rdata,
    output logic              d_stall,
    input  logic              longest_stall,
    cpu_mem_arbiter_if.master mem
);

    arb_state_t state, state_nx;
    logic       i_done, d_done;
    logic       i_set, d_set;
    logic       ip, dp;

    assign ip      = inst_req & ~i_done;
    assign dp      = data_req & ~d_done;
    assign i_stall = ip;
    assign d_stall = dp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx      = state;
        i_set         = 1'b0;
        d_set         = 1'b0;
        mem.mem_req   = 1'b0;
        mem.mem_wen   = '0;
        mem.mem_addr  = '0;
        mem.mem_wdata = '0;
        unique case (state)
            IDLE: begin
                if (dp && (DATA_FIRST || !ip)) begin
                    state_nx = D_ADDR;
                end else if (ip) begin
                    state_nx = I_ADDR;
                end
            end
            I_ADDR: begin
                mem.mem_req  = 1'b1;
                mem.mem_addr = inst_addr;
                if (mem.mem_addr_ok) begin
                    state_nx = I_DATA;
                end
            end
            I_DATA: begin
                if (mem.mem_data_ok) begin
                    i_set    = 1'b1;
                    state_nx = IDLE;
                end
            end
            D_ADDR: begin
                mem.mem_req   = 1'b1;
                mem.mem_wen   = data_wen;
                mem.mem_addr  = data_addr;
                mem.mem_wdata = data_wdata;
                if (mem.mem_addr_ok) begin
                    state_nx = D_DATA;
                end
            end
            D_DATA: begin
                if (mem.mem_data_ok) begin
                    d_set    = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Done flags survive until the whole pipeline advances, so a finished side is not re-fetched.
    cpu_mem_arbiter_resp_buf #(.DW(DW)) u_inst_buf (
        .clk  (clk),
        .rst  (rst),
        .set  (i_set),
        .clr  (~longest_stall),
        .din  (mem.mem_rdata),
        .dout (inst_rdata),
        .done (i_done)
    );

    cpu_mem_arbiter_resp_buf #(.DW(DW)) u_data_buf (
        .clk  (clk),
        .rst  (rst),
        .set  (d_set),
        .clr  (~longest_stall),
        .din  (mem.mem_rdata),
        .dout (data_rdata),
        .done (d_done)
    );

`ifndef SYNTHESIS
    a_inst_req_held: assert property (@(posedge clk) disable iff (rst) i_stall |=> inst_req)
        else $error("inst_req dropped while i_stall was high");
    a_data_req_held: assert property (@(posedge clk) disable iff (rst) d_stall |=> data_req)
        else $error("data_req dropped while d_stall was high");
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Directed bench for cpu_mem_arbiter: transaction-level model checked every cycle plus literal pins.
module tb_cpu_mem_arbiter;
    import cpu_mem_arbiter_pkg::*;

    localparam bit DF       = 1'b1;
    localparam int OWN_NONE = 0;
    localparam int OWN_I    = 1;
    localparam int OWN_D    = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        inst_req = 1'b0;
    logic [31:0] inst_addr = '0;
    logic [31:0] inst_rdata;
    logic        i_stall;
    logic        data_req = 1'b0;
    logic [3:0]  data_wen = '0;
    logic [31:0] data_addr = '0;
    logic [31:0] data_wdata = '0;
    logic [31:0] data_rdata;
    logic        d_stall;
    logic        hold = 1'b0;
    logic        longest_stall;

    int total = 0;
    int bad   = 0;

    int a_delay = 0;
    int d_delay = 0;
    bit spurious = 1'b0;

    logic [31:0] issue_addr[$];
    logic [3:0]  issue_wen[$];
    logic [31:0] issue_wdata[$];
    int          req_cycles = 0;

    cpu_mem_arbiter_if mem_if ();

    cpu_mem_arbiter #(.DATA_FIRST(DF)) dut (
        .clk           (clk),
        .rst           (rst),
        .inst_req      (inst_req),
        .inst_addr     (inst_addr),
        .inst_rdata    (inst_rdata),
        .i_stall       (i_stall),
        .data_req      (data_req),
        .data_wen      (data_wen),
        .data_addr     (data_addr),
        .data_wdata    (data_wdata),
        .data_rdata    (data_rdata),
        .d_stall       (d_stall),
        .longest_stall (longest_stall),
        .mem           (mem_if)
    );

    // Datapath side: the pipeline stalls if anything stalls or the bench holds it.
    assign longest_stall = hold | i_stall | d_stall;

    always #5 clk = ~clk;

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        case (a)
            32'hBFC0_0000: return 32'h2408_0001;
            32'hBFC0_0004: return 32'h3C1D_BFC1;
            32'h8000_0010: return 32'hCAFE_F00D;
            default:       return a ^ 32'hA5A5_A5A5;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Memory slave: addr_ok after a_delay request cycles, data_ok after d_delay wait cycles.
    bit          s_pend = 1'b0;
    int          a_cnt = 0;
    int          d_cnt = 0;
    logic [31:0] s_addr = '0;
    bit          s_acc, s_fin;
    logic [31:0] s_acc_addr;

    initial begin
        mem_if.mem_addr_ok = 1'b0;
        mem_if.mem_data_ok = 1'b0;
        mem_if.mem_rdata   = '0;
        forever begin
            @(negedge clk);
            s_acc      = mem_if.mem_req && mem_if.mem_addr_ok;
            s_acc_addr = mem_if.mem_addr;
            s_fin      = s_pend && mem_if.mem_data_ok;
            @(posedge clk);
            #1;
            if (rst) begin
                s_pend = 1'b0;
                a_cnt  = 0;
                d_cnt  = 0;
                mem_if.mem_addr_ok = 1'b0;
                mem_if.mem_data_ok = 1'b0;
                mem_if.mem_rdata   = '0;
            end else begin
                if (s_fin) s_pend = 1'b0;
                if (s_acc) begin
                    s_pend = 1'b1;
                    s_addr = s_acc_addr;
                    a_cnt  = 0;
                    d_cnt  = 0;
                end
                if (s_pend) begin
                    mem_if.mem_data_ok = (d_cnt >= d_delay);
                    mem_if.mem_rdata   = mem_if.mem_data_ok ? rd_val(s_addr) : 32'h0BAD_0BAD;
                    d_cnt++;
                end else begin
                    mem_if.mem_data_ok = spurious;
                    mem_if.mem_rdata   = spurious ? 32'hDEAD_BEEF : 32'h0;
                end
                if (mem_if.mem_req) begin
                    mem_if.mem_addr_ok = (a_cnt >= a_delay);
                    a_cnt++;
                end else begin
                    mem_if.mem_addr_ok = 1'b0;
                end
            end
        end
    end

    // Transaction model: who owns the port, whether the address was taken, per-side done/buffer.
    int          m_own   = OWN_NONE;
    bit          m_acc   = 1'b0;
    bit          m_idone = 1'b0;
    bit          m_ddone = 1'b0;
    logic [31:0] m_ibuf  = '0;
    logic [31:0] m_dbuf  = '0;

    always @(posedge clk or posedge rst) begin
        bit ip, dp, lst, set_i, set_d;
        if (rst) begin
            m_own   = OWN_NONE;
            m_acc   = 1'b0;
            m_idone = 1'b0;
            m_ddone = 1'b0;
            m_ibuf  = '0;
            m_dbuf  = '0;
        end else begin
            ip    = inst_req && !m_idone;
            dp    = data_req && !m_ddone;
            lst   = hold || ip || dp;
            set_i = 1'b0;
            set_d = 1'b0;
            if (m_own == OWN_NONE) begin
                if (dp && (DF || !ip)) m_own = OWN_D;
                else if (ip)           m_own = OWN_I;
                m_acc = 1'b0;
            end else if (!m_acc) begin
                if (mem_if.mem_addr_ok) m_acc = 1'b1;
            end else if (mem_if.mem_data_ok) begin
                if (m_own == OWN_I) begin
                    m_ibuf = mem_if.mem_rdata;
                    set_i  = 1'b1;
                end else begin
                    m_dbuf = mem_if.mem_rdata;
                    set_d  = 1'b1;
                end
                m_own = OWN_NONE;
            end
            if (!lst) begin
                m_idone = 1'b0;
                m_ddone = 1'b0;
            end
            if (set_i) m_idone = 1'b1;
            if (set_d) m_ddone = 1'b1;
        end
    end

    always @(negedge clk) begin
        logic        e_req;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_wen;
        e_req   = (m_own != OWN_NONE) && !m_acc;
        e_addr  = '0;
        e_wen   = '0;
        e_wdata = '0;
        if (e_req && m_own == OWN_I) begin
            e_addr = inst_addr;
        end else if (e_req) begin
            e_addr  = data_addr;
            e_wen   = data_wen;
            e_wdata = data_wdata;
        end
        check("i_stall",    i_stall,          inst_req && !m_idone);
        check("d_stall",    d_stall,          data_req && !m_ddone);
        check("inst_rdata", inst_rdata,       m_ibuf);
        check("data_rdata", data_rdata,       m_dbuf);
        check("mem_req",    mem_if.mem_req,   e_req);
        check("mem_addr",   mem_if.mem_addr,  e_addr);
        check("mem_wen",    mem_if.mem_wen,   e_wen);
        check("mem_wdata",  mem_if.mem_wdata, e_wdata);
        if (!rst && mem_if.mem_req) req_cycles++;
        if (!rst && mem_if.mem_req && mem_if.mem_addr_ok) begin
            issue_addr.push_back(mem_if.mem_addr);
            issue_wen.push_back(mem_if.mem_wen);
            issue_wdata.push_back(mem_if.mem_wdata);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_stalls(input string name, output int n);
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (!i_stall && !d_stall) break;
            n++;
            if (n > 60) begin
                total++;
                bad++;
                $display("FAIL %s: stall still high after %0d cycles, want it low", name, n);
                break;
            end
        end
    endtask

    initial begin
        int n, n0, r0, guard;
        repeat (3) @(negedge clk);
        #1;
        check("reset_inst_rdata", inst_rdata,      32'h0);
        check("reset_data_rdata", data_rdata,      32'h0);
        check("reset_mem_req",    mem_if.mem_req,  1'b0);
        check("reset_mem_addr",   mem_if.mem_addr, 32'h0);
        rst = 1'b0;

        // 1: single fetch
        next_cycle();
        n0 = issue_addr.size();
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0000;
        wait_stalls("t1_wait", n);
        check("t1_stall_cycles", n, 3);
        check("t1_inst_rdata", inst_rdata, 32'h2408_0001);
        check("t1_issues", issue_addr.size() - n0, 1);
        check("t1_mem_wen", issue_wen[n0], 4'b0000);

        // 2: simultaneous load and fetch, data first
        next_cycle();
        n0 = issue_addr.size();
        inst_addr = 32'hBFC0_0004;
        data_req  = 1'b1;
        data_wen  = 4'b0000;
        data_addr = 32'h8000_0010;
        wait_stalls("t2_wait", n);
        check("t2_stall_cycles", n, 6);
        check("t2_issues", issue_addr.size() - n0, 2);
        check("t2_first_addr", issue_addr[n0], 32'h8000_0010);
        check("t2_second_addr", issue_addr[n0+1], 32'hBFC0_0004);
        check("t2_data_rdata", data_rdata, 32'hCAFE_F00D);
        check("t2_inst_rdata", inst_rdata, 32'h3C1D_BFC1);

        // 3: store only
        next_cycle();
        n0 = issue_addr.size();
        inst_req   = 1'b0;
        data_wen   = 4'b0011;
        data_addr  = 32'h8000_0020;
        data_wdata = 32'h0000_ABCD;
        wait_stalls("t3_wait", n);
        check("t3_stall_cycles", n, 3);
        check("t3_issues", issue_addr.size() - n0, 1);
        check("t3_mem_wen", issue_wen[n0], 4'b0011);
        check("t3_mem_wdata", issue_wdata[n0], 32'h0000_ABCD);

        // 4: addr_ok delayed 4 cycles
        next_cycle();
        n0 = issue_addr.size();
        r0 = req_cycles;
        a_delay   = 4;
        data_req  = 1'b0;
        data_wen  = 4'b0000;
        data_wdata = 32'h0;
        inst_req  = 1'b1;
        inst_addr = 32'hBFC0_0008;
        wait_stalls("t4_wait", n);
        check("t4_stall_cycles", n, 7);
        check("t4_req_cycles", req_cycles - r0, 5);
        check("t4_issues", issue_addr.size() - n0, 1);
        check("t4_inst_rdata", inst_rdata, 32'h1A65_A5AD);

        // 5: pipeline held after the fetch completes, stray data_ok while idle
        next_cycle();
        a_delay   = 0;
        hold      = 1'b1;
        inst_addr = 32'hBFC0_000C;
        wait_stalls("t5_wait", n);
        check("t5_stall_cycles", n, 3);
        n0 = issue_addr.size();
        spurious = 1'b1;
        repeat (5) begin
            @(negedge clk);
            #1;
            check("t5_rdata_held", inst_rdata, 32'h1A65_A5A9);
            check("t5_no_stall", i_stall, 1'b0);
        end
        spurious = 1'b0;
        check("t5_no_reissue", issue_addr.size() - n0, 0);
        next_cycle();
        hold = 1'b0;
        @(negedge clk);
        #1;
        check("t5_done_kept_until_edge", i_stall, 1'b0);
        @(negedge clk);
        #1;
        check("t5_done_cleared", i_stall, 1'b1);
        wait_stalls("t5_refetch", n);
        check("t5_refetch_issues", issue_addr.size() - n0, 1);
        check("t5_refetch_rdata", inst_rdata, 32'h1A65_A5A9);

        // 6: reset while the fetch waits for data
        next_cycle();
        d_delay   = 3;
        inst_addr = 32'hBFC0_0000;
        n0 = issue_addr.size();
        guard = 0;
        while (issue_addr.size() == n0 && guard < 40) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("t6_reached_addr", issue_addr.size() - n0, 1);
        next_cycle();
        rst = 1'b1;
        #1;
        check("t6_rst_mem_req", mem_if.mem_req, 1'b0);
        check("t6_rst_inst_rdata", inst_rdata, 32'h0);
        check("t6_rst_data_rdata", data_rdata, 32'h0);
        check("t6_rst_i_stall", i_stall, 1'b1);
        @(negedge clk);
        #1;
        d_delay = 0;
        @(negedge clk);
        #1;
        rst = 1'b0;
        n0 = issue_addr.size();
        wait_stalls("t6_reissue", n);
        check("t6_reissue_count", issue_addr.size() - n0, 1);
        check("t6_reissue_addr", issue_addr[n0], 32'hBFC0_0000);
        check("t6_reissue_rdata", inst_rdata, 32'h2408_0001);

        next_cycle();
        inst_req = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("end_idle_mem_req", mem_if.mem_req, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exhausted, want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
